mod5_rr_arbiter: RTL

MOD5_RR_ARBITER -- requirements
Module: mod5_rr_arbiter

---
 rtl/mod5_rr_arbiter_pkg.sv | 17 +
 rtl/mod5_rr_arbiter_if.sv | 19 +
 rtl/mod5_ptr.sv | 28 ++
 rtl/mod5_rr_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/mod5_rr_arbiter_pkg.sv
// rtl/mod5_rr_arbiter_pkg.sv - shared types and constants for the mod-5 round-robin arbiter
// Holds the FSM state encoding, the requester count and the pointer wrap limit.
package mod5_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   // Requester count; the arbiter is built for exactly five requesters.
   localparam int REQ_COUNT = 5;

   // Highest legal pointer value; anything loaded above this wraps to 0.
   localparam logic [2:0] PTR_WRAP = 3'd4;

endpackage

// File: rtl/mod5_rr_arbiter_if.sv
// rtl/mod5_rr_arbiter_if.sv - request/grant bundle between requesters and the arbiter
// Signals:
//   req    : per-requester request level, bit i = requester i
//   gnt    : one-hot grant (or all-zero)
//   gnt_id : index of the granted requester, 0 when nothing is granted
//   busy   : high while a grant is held
// Modports: master = requester side, slave = arbiter side.
interface mod5_rr_arbiter_if;
   import mod5_rr_arbiter_pkg::*;

   logic [REQ_COUNT-1:0] req;
   logic [REQ_COUNT-1:0] gnt;
   logic [2:0]           gnt_id;
   logic                 busy;

   modport master (output req, input gnt, input gnt_id, input busy);
   modport slave  (input req, output gnt, output gnt_id, output busy);

endinterface

// File: rtl/mod5_ptr.sv
// rtl/mod5_ptr.sv - round-robin priority pointer with load-and-wrap
// Ports:
//   clk      : clock
//   rst      : synchronous active-low reset, clears ptr to 0
//   load     : load enable
//   load_val : candidate value; values above 4 wrap to 0
//   ptr      : current priority pointer, always 0..4
module mod5_ptr
   import mod5_rr_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [2:0] load_val,
   output logic [2:0] ptr
);

   // The caller hands in "last winner + 1"; folding 5 back to 0 here keeps
   // the pointer inside 0..4 no matter what arrives.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr <= 3'd0;
      end else if (load) begin
         ptr <= (load_val > PTR_WRAP) ? 3'd0 : load_val;
      end
   end

endmodule

// File: rtl/mod5_rr_arbiter.sv
// rtl/mod5_rr_arbiter.sv - five-way round-robin arbiter with bounded tenure
// Ports:
//   clk : clock, all state on rising edge
//   rst : synchronous active-low reset
//   bus : mod5_rr_arbiter_if.slave (req in; gnt, gnt_id, busy out, all registered)
// Parameters:
//   MAX_HOLD : maximum consecutive grant cycles per tenure (1..7)
//   NUM_REQ  : requester count, fixed at 5
module mod5_rr_arbiter
   import mod5_rr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int NUM_REQ  = 5
)
(
   input  logic               clk,
   input  logic               rst,
   mod5_rr_arbiter_if.slave   bus
);

   state_t     state;
   logic [2:0] hold_cnt;
   logic [2:0] ptr;
   logic [2:0] winner;
   logic [3:0] idx;
   logic       tenure_end;

   // Walk the search order from the far end back toward ptr so the last
   // assignment is the requester closest to ptr, which is the one that wins.
   always_comb begin
      winner = 3'd0;
      idx    = 4'd0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, ptr} + 4'(k);
         if (idx > 4'd4) begin
            idx = idx - 4'd5;
         end
         if (bus.req[idx[2:0]]) begin
            winner = idx[2:0];
         end
      end
   end

   // A tenure ends when the owner drops its request or the hold limit is
   // reached; both at once is still a single release.
   assign tenure_end = (state == GRANT) &&
                       (!bus.req[bus.gnt_id] || (hold_cnt == 3'(MAX_HOLD)));

   mod5_ptr u_ptr (
      .clk      (clk),
      .rst      (rst),
      .load     (tenure_end),
      .load_val (bus.gnt_id + 3'd1),
      .ptr      (ptr)
   );

   // RELEASE is the mandatory dead cycle after a tenure; it arbitrates at its
   // closing edge like IDLE, so consecutive tenures are separated by exactly
   // one gnt=0 cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         bus.gnt    <= '0;
         bus.gnt_id <= 3'd0;
         bus.busy   <= 1'b0;
         hold_cnt <= 3'd0;
      end else begin
         case (state)
            IDLE, RELEASE: begin
               if (|bus.req) begin
                  bus.gnt    <= 5'b00001 << winner;
                  bus.gnt_id <= winner;
                  bus.busy   <= 1'b1;
                  hold_cnt <= 3'd1;
                  state    <= GRANT;
               end else begin
                  state    <= IDLE;
               end
            end
            GRANT: begin
               if (tenure_end) begin
                  bus.gnt    <= '0;
                  bus.gnt_id <= 3'd0;
                  bus.busy   <= 1'b0;
                  hold_cnt <= 3'd0;
                  state    <= RELEASE;
               end else begin
                  hold_cnt <= hold_cnt + 3'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
